// File: rtl/key_event_ctrl.sv
// Key press classifier: turns the debounced, active-low key level into held
// short/long press requests with an ack handshake and a sticky overrun flag.
module key_event_ctrl #(
    parameter int unsigned LONG_CYCLES = 1000,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    input  logic ack,
    output logic short_req,
    output logic long_req,
    output logic pressed,
    output logic overrun
);

    typedef enum logic [1:0] {
        S_WAIT_RELEASE,
        S_IDLE,
        S_HOLD,
        S_LONG
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 short_req_q, short_req_d;
    logic                 long_req_q, long_req_d;
    logic                 pressed_q, pressed_d;
    logic                 overrun_q, overrun_d;
    logic                 short_ev;
    logic                 long_ev;
    logic                 pending;
    logic                 pending_after_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_WAIT_RELEASE;
            cnt_q       <= '0;
            short_req_q <= 1'b0;
            long_req_q  <= 1'b0;
            pressed_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            short_req_q <= short_req_d;
            long_req_q  <= long_req_d;
            pressed_q   <= pressed_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        short_ev          = 1'b0;
        long_ev           = 1'b0;
        short_req_d       = short_req_q;
        long_req_d        = long_req_q;
        overrun_d         = overrun_q;
        pending           = short_req_q | long_req_q;
        pending_after_ack = pending & ~ack;

        case (state_q)
            S_WAIT_RELEASE: begin
                if (key_n) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!key_n) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_ONE;
                end
            end
            S_HOLD: begin
                if (key_n) begin
                    state_d  = S_IDLE;
                    short_ev = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LONG;
                    long_ev = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LONG: begin
                if (key_n) state_d = S_IDLE;
            end
            default: state_d = S_WAIT_RELEASE;
        endcase

        // Ack is applied first so an event on the same edge lands without a gap.
        if (ack && pending) begin
            short_req_d = 1'b0;
            long_req_d  = 1'b0;
            overrun_d   = 1'b0;
        end
        if (short_ev || long_ev) begin
            if (!pending_after_ack) begin
                short_req_d = short_ev;
                long_req_d  = long_ev;
            end else begin
                overrun_d = 1'b1;
            end
        end

        pressed_d = (state_d == S_HOLD) || (state_d == S_LONG);
    end

    assign short_req = short_req_q;
    assign long_req  = long_req_q;
    assign pressed   = pressed_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: press-length model compared every cycle, plus
// directed literal checks of short/long/threshold/overrun/reset behaviour.
module tb_key_event_ctrl;

    localparam int unsigned LONG = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_n = 1'b1;
    logic ack = 1'b0;
    logic short_req, long_req, pressed, overrun;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    // Model state: armed after first release, length of current low run,
    // pending request kind (0 none, 1 short, 2 long), sticky overrun.
    bit armed;
    int run;
    int m_req;
    bit m_over;
    bit m_pressed;

    key_event_ctrl #(.LONG_CYCLES(LONG), .CNT_WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .key_n    (key_n),
        .ack      (ack),
        .short_req(short_req),
        .long_req (long_req),
        .pressed  (pressed),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or posedge reset) begin
        int ev;
        if (reset) begin
            armed = 0; run = 0; m_req = 0; m_over = 0; m_pressed = 0;
        end else begin
            ev = 0;
            if (!armed) begin
                if (key_n) armed = 1;
            end else if (!key_n) begin
                run++;
                if (run == int'(LONG)) ev = 2;
            end else begin
                if (run > 0 && run < int'(LONG)) ev = 1;
                run = 0;
            end
            if (ack && m_req != 0) begin
                m_req = 0; m_over = 0;
            end
            if (ev != 0) begin
                if (m_req == 0) m_req = ev;
                else m_over = 1;
            end
            m_pressed = armed && run > 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("model_short", short_req, m_req == 1);
            chk("model_long", long_req, m_req == 2);
            chk("model_pressed", pressed, m_pressed);
            chk("model_overrun", overrun, m_over);
        end
    end

    task automatic step(input logic k, input logic a);
        @(negedge clk);
        key_n = k;
        ack   = a;
    endtask

    task automatic low(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_short", short_req, 1'b0);
        chk("rst_long", long_req, 1'b0);
        chk("rst_pressed", pressed, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        reset = 1'b0;
        repeat (3) step(1'b1, 1'b0);

        // Short press of 5 samples, then ack
        low(5);
        settle(); chk("short_pressed_hold", pressed, 1'b1);
        step(1'b1, 1'b0);
        settle(); chk("short_req_rise", short_req, 1'b1);
        chk("short_pressed_fall", pressed, 1'b0);
        chk("short_no_long", long_req, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        settle(); chk("short_req_held", short_req, 1'b1);
        step(1'b1, 1'b1);
        settle(); chk("short_ack_clear", short_req, 1'b0);
        step(1'b1, 1'b0);

        // Long press of 20 samples
        low(7);
        settle(); chk("long_before_thr", long_req, 1'b0);
        step(1'b0, 1'b0);
        settle(); chk("long_at_8th", long_req, 1'b1);
        chk("long_pressed", pressed, 1'b1);
        low(12);
        step(1'b1, 1'b0);
        settle(); chk("long_release_no_short", short_req, 1'b0);
        chk("long_release_held", long_req, 1'b1);
        chk("long_release_pressed", pressed, 1'b0);
        step(1'b1, 1'b1);
        settle(); chk("long_ack_clear", long_req, 1'b0);
        step(1'b1, 1'b0);

        // Threshold: 7 lows short, 8 lows long
        low(7);
        step(1'b1, 1'b0);
        settle(); chk("thr7_short", short_req, 1'b1);
        chk("thr7_no_long", long_req, 1'b0);
        step(1'b1, 1'b1);
        low(8);
        step(1'b1, 1'b0);
        settle(); chk("thr8_long", long_req, 1'b1);
        chk("thr8_no_short", short_req, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);

        // Ack with nothing pending is a no-op
        step(1'b1, 1'b1);
        settle(); chk("idle_ack_short", short_req, 1'b0);
        chk("idle_ack_overrun", overrun, 1'b0);
        step(1'b1, 1'b0);

        // Overrun: two short presses without ack
        low(3);
        step(1'b1, 1'b0);
        low(3);
        step(1'b1, 1'b0);
        settle(); chk("ovr_short_kept", short_req, 1'b1);
        chk("ovr_flag", overrun, 1'b1);
        step(1'b1, 1'b1);
        settle(); chk("ovr_ack_short", short_req, 1'b0);
        chk("ovr_ack_flag", overrun, 1'b0);
        step(1'b1, 1'b0);

        // Event coinciding with ack: no gap, no overrun
        low(3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        low(3);
        step(1'b1, 1'b1);
        settle(); chk("simul_short", short_req, 1'b1);
        chk("simul_no_ovr", overrun, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        settle(); chk("simul_ack_clear", short_req, 1'b0);
        step(1'b1, 1'b0);

        // Reset during a held key, then key still held after release
        low(3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_pressed", pressed, 1'b0);
        chk("rst_mid_short", short_req, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        low(30);
        settle(); chk("held_after_rst_pressed", pressed, 1'b0);
        chk("held_after_rst_short", short_req, 1'b0);
        chk("held_after_rst_long", long_req, 1'b0);
        step(1'b1, 1'b0);
        low(3);
        step(1'b1, 1'b0);
        settle(); chk("rearm_short", short_req, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Sits directly downstream of the executor's push-button debouncer.
- Consumes the debounced, L-active key level and classifies each press as short or long.
- Presents each press to the executor control logic as a held request with a ready/ack-style handshake.
- Also flags presses that were lost because the previous request had not yet been acknowledged.

Parameters:
- LONG_CYCLES, 1000: number of consecutive low samples of key_n that make a press "long"; legal range 2 .. 2**CNT_WIDTH-1.
- CNT_WIDTH, 16: width of the hold counter.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- reset  input  1  asynchronous, active-high reset.
- key_n  input  1  debounced key level, L-active; source updates on negedge clk, so posedge sampling sees a settled value.
- ack  input  1  executor acknowledge; sampled on posedge clk.
- short_req  output  1  short-press request, active-high; held until acknowledged.
- long_req  output  1  long-press request, active-high; held until acknowledged.
- pressed  output  1  active-high; key currently held and armed.
- overrun  output  1  sticky flag: a press event was dropped.

Behaviour:
- Reset (async assert):
  - state = WAIT_RELEASE, hold counter = 0.
  - short_req = 0, long_req = 0, pressed = 0, overrun = 0.
- FSM states: WAIT_RELEASE, IDLE, HOLD, LONG. All transitions occur on posedge clk.
  - WAIT_RELEASE: if key_n = 1, go to IDLE. A key already held at reset release therefore never produces an event.
  - IDLE: if key_n = 0, go to HOLD and load counter = 1.
  - HOLD, key_n = 1: go to IDLE and raise a short event.
  - HOLD, key_n = 0 and counter = LONG_CYCLES-1: go to LONG and raise a long event.
  - HOLD, otherwise: counter increments by 1.
  - LONG: if key_n = 1, go to IDLE. No event is raised on release after a long press.
- pressed is 1 exactly in HOLD and LONG (registered from the state).
- Timing:
  - A press that is low for N consecutive posedge samples is short if N <= LONG_CYCLES-1.
  - short_req rises at the edge where key_n is first sampled high.
  - A press is long once N reaches LONG_CYCLES.
  - long_req rises at the LONG_CYCLES-th low sample edge, while the key is still held.
- Counter:
  - Width is CNT_WIDTH.
  - It never exceeds LONG_CYCLES-1, so it never wraps.
  - It is held at its value in LONG; its content is don't-care outside HOLD.
- Handshake:
  - A request, once set, stays 1 until ack is sampled high.
  - At that edge both short_req and long_req clear, and overrun clears.
  - ack while no request is pending has no effect.
- Event acceptance:
  - An event is accepted if no request is pending after the ack of that same edge has been applied.
  - An accepted event sets its own request.
  - Event and ack at the same edge: the old request is cleared, the new event is accepted, and the new request is 1 after the edge (there is no gap cycle, even for the same request type).
  - Event while a request is pending and ack is low: the event is dropped, overrun is set to 1, and the pending request is unchanged.
- short_req and long_req are never 1 simultaneously.
- Reset mid-press or with a request pending:
  - All outputs drop immediately.
  - The pending request is lost.
  - The block stays in WAIT_RELEASE until the key is seen released.

Test Plan:
- Short press (LONG_CYCLES=8): key_n low for 5 samples, then high; ack held 0 → short_req = 1 from the release edge and stays 1. Raising ack for 1 cycle → short_req = 0 at that edge; long_req stays 0 throughout; pressed = 1 for 5 cycles.
- Long press (LONG_CYCLES=8): key_n low for 20 samples → long_req = 1 at the 8th low sample edge. Release → no short_req; pressed falls at the release edge. ack → long_req = 0.
- Threshold check (LONG_CYCLES=8):
  - 7 low samples → short_req only.
  - 8 low samples → long_req only.
- Overrun: two short presses without ack → first short_req stays 1, second press dropped, overrun = 1. One ack pulse → short_req = 0 and overrun = 0.
- Simultaneous events: ack asserted at the same edge as the release of a second short press → short_req remains 1 continuously and overrun stays 0. A further ack → short_req = 0.
- Reset during a held key: assert reset mid-HOLD with key_n = 0, then release reset with key_n still 0 for 30 cycles → all outputs stay 0. Key_n high for 1 cycle, then low for 3 and high → short_req = 1.
